// File: rtl/cordic_result_serializer.sv
// Buffers CORDIC {phase, magnitude} results in a small FIFO and streams each one LSB-first as bytes.
// Optional build macro SERIALIZER_CHECKSUM_EN appends an XOR checksum byte to every frame.
module cordic_result_serializer #(
    parameter int MAG_W   = 16,
    parameter int PHASE_W = 32,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               res_valid,
    output logic               res_ready,
    input  logic [MAG_W-1:0]   res_mag,
    input  logic [PHASE_W-1:0] res_phase,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               busy
);
    localparam int EW = MAG_W + PHASE_W;
    localparam int NB = EW / 8;
`ifdef SERIALIZER_CHECKSUM_EN
    localparam int FL = NB + 1;
`else
    localparam int FL = NB;
`endif
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(FL);

    logic [EW-1:0] fifo [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] idx;
    logic          push;
    logic          xfer;
    logic          pop;
    logic [EW-1:0] head;
    logic [7:0]    byte_sel;
`ifdef SERIALIZER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign res_ready = ena & (count != CW'(DEPTH));
    assign out_valid = ena & (count != '0);
    assign busy      = (count != '0);
    assign push      = res_valid & res_ready;
    assign xfer      = out_valid & out_ready;
    assign pop       = xfer & (idx == IW'(FL - 1));

    // Storage is deliberately not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= {res_phase, res_mag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            idx    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (xfer) begin
                if (pop) begin
                    idx    <= '0;
                    rd_ptr <= rd_ptr + PW'(1);
                end else begin
                    idx <= idx + IW'(1);
                end
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head     = fifo[rd_ptr];
        byte_sel = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (idx == IW'(i)) begin
                byte_sel = head[i*8 +: 8];
            end
        end
`ifdef SERIALIZER_CHECKSUM_EN
        csum = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            csum = csum ^ head[i*8 +: 8];
        end
        if (idx == IW'(NB)) begin
            byte_sel = csum;
        end
`endif
        out_data = (count != '0) ? byte_sel : '0;
    end

endmodule

// File: tb/tb_cordic_result_serializer.sv
// Scoreboard bench for cordic_result_serializer: expected byte stream built from the frame format,
// compared every cycle together with the handshake flags.
module tb_cordic_result_serializer;
    localparam int MAG_W   = 16;
    localparam int PHASE_W = 32;
    localparam int DEPTH   = 2;
    localparam int NB      = (MAG_W + PHASE_W) / 8;
`ifdef SERIALIZER_CHECKSUM_EN
    localparam int FL = NB + 1;
`else
    localparam int FL = NB;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ena = 1'b0;
    logic               res_valid = 1'b0;
    logic               res_ready;
    logic [MAG_W-1:0]   res_mag = '0;
    logic [PHASE_W-1:0] res_phase = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [7:0]         out_data;
    logic               busy;

    int passed = 0;
    int total  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];

    cordic_result_serializer #(.MAG_W(MAG_W), .PHASE_W(PHASE_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_mag(res_mag), .res_phase(res_phase),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void add_frame(input logic [15:0] m, input logic [31:0] p);
        logic [47:0] d;
        logic [7:0]  b;
        logic [7:0]  cs;
        d  = {p, m};
        cs = '0;
        for (int i = 0; i < NB; i++) begin
            b  = d[i*8 +: 8];
            cs = cs ^ b;
            exp_q.push_back(b);
        end
`ifdef SERIALIZER_CHECKSUM_EN
        exp_q.push_back(cs);
`else
        cs = cs; // unused without the checksum byte
`endif
    endfunction

    // Monitor/scoreboard: compares flags and data, then applies the handshakes the next edge will do.
    always @(negedge clk) begin
        int   frames;
        logic e_busy;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            frames = (exp_q.size() + FL - 1) / FL;
            e_busy = (exp_q.size() != 0);
            chk("busy", busy, e_busy);
            chk("out_valid", out_valid, ena && e_busy);
            chk("res_ready", res_ready, ena && (frames < DEPTH));
            chk("out_data", out_data, e_busy ? exp_q[0] : 8'h00);
            if (ena && e_busy && out_ready) begin
                log_q.push_back(out_data);
                void'(exp_q.pop_front());
            end
            if (ena && (frames < DEPTH) && res_valid) add_frame(res_mag, res_phase);
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the result.
    task automatic push(input logic [15:0] m, input logic [31:0] p);
        int n;
        n = 0;
        res_mag   = m;
        res_phase = p;
        res_valid = 1'b1;
        @(negedge clk);
        while (!res_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1 res_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] basic [7];
        basic = '{8'h34, 8'h12, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h22};

        ena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_res_ready", res_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic frame
        out_ready = 1'b1;
        log_q.delete();
        push(16'h1234, 32'hA1B2C3D4);
        wait_idle();
        chk("basic_len", log_q.size(), FL);
        for (int i = 0; i < FL; i++) chk("basic_byte", (i < log_q.size()) ? log_q[i] : 8'hxx, basic[i]);

        // full FIFO, held-off third result, then drain without gaps
        out_ready = 1'b0;
        push(16'h1111, 32'h22223333);
        push(16'h4444, 32'h55556666);
        chk("full_res_ready", res_ready, 0);
        res_mag   = 16'h7777;
        res_phase = 32'h88889999;
        res_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("full_held_busy", busy, 1);
        out_ready = 1'b1;
        push(16'h7777, 32'h88889999);
        wait_idle();

        // backpressure mid-frame
        push(16'hBEEF, 32'hDEADC0DE);
        repeat (2) @(posedge clk);
        foreach (basic[k]) begin
            if (k < 4) begin
                out_ready = (k == 0 || k == 3);
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        wait_idle();

        // async reset mid-frame with a second result queued
        out_ready = 1'b0;
        push(16'hA5A5, 32'h01234567);
        push(16'h5A5A, 32'h89ABCDEF);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        log_q.delete();
        push(16'hC3D2, 32'h0F1E2D3C);
        wait_idle();
        chk("post_rst_byte0", (log_q.size() > 0) ? log_q[0] : 8'hxx, 8'hD2);
        chk("post_rst_len", log_q.size(), FL);

        // ena gating mid-frame
        push(16'h0102, 32'h03040506);
        repeat (2) @(posedge clk);
        #1 ena = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ena_res_ready", res_ready, 0);
        ena = 1'b1;
        wait_idle();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            res_valid = ($urandom_range(0, 2) != 0);
            res_mag   = 16'($urandom);
            res_phase = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            ena       = ($urandom_range(0, 9) != 0);
            @(posedge clk);
            #1;
        end
        res_valid = 1'b0;
        ena       = 1'b1;
        out_ready = 1'b1;
        wait_idle();
        chk("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
